// File: rtl/out_port_uart_pkg.sv
// Shared types and constants for the output-port UART transmitter.
package out_port_uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uartState_e;

endpackage

// File: rtl/byte_fifo.sv
// Generic synchronous first-word-fall-through byte FIFO with occupancy count.
// A push on full is accepted only when a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               din_i,
    output logic [7:0]               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr_q;
    logic [ADDR_W-1:0] rdPtr_q;
    logic [LVL_W-1:0]  level_q;
    logic              doPush;
    logic              doPop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem[rdPtr_q];
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + ADDR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + ADDR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/out_port_uart_tx.sv
// Consumer of the CPU byte-output port: every toggle of in_ctl queues in_dat,
// and the queue is drained as back-to-back 8N1 UART frames on uart_tx.
module out_port_uart_tx
    import out_port_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 16,
    parameter int SYNC_STAGES  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_dat,
    input  logic                     in_ctl,
    input  logic                     clr_ovf,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);

    logic              ctlS;
    logic [7:0]        datS;
    logic              ctlRef_q;
    logic              ovf_q;
    logic              ovf_d;
    logic              fifoPush;
    logic              fifoPop;
    logic [7:0]        fifoDout;
    logic              fifoFull;
    logic              fifoEmpty;

    uartState_e        state_q;
    uartState_e        state_d;
    logic [BAUD_W-1:0] baudCnt_q;
    logic [BAUD_W-1:0] baudCnt_d;
    logic [2:0]        bitCnt_q;
    logic [2:0]        bitCnt_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              tx_q;
    logic              tx_d;
    logic              baudDone;

    if (SYNC_STAGES == 0) begin : g_noSync
        assign ctlS = in_ctl;
        assign datS = in_dat;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] ctlSync_q;
        logic [7:0]             datSync_q [SYNC_STAGES];

        // Equal-depth delay lines so the byte always travels alongside its strobe.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctlSync_q <= '0;
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    datSync_q[i] <= '0;
                end
            end else begin
                ctlSync_q[0] <= in_ctl;
                datSync_q[0] <= in_dat;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    ctlSync_q[i] <= ctlSync_q[i-1];
                    datSync_q[i] <= datSync_q[i-1];
                end
            end
        end

        assign ctlS = ctlSync_q[SYNC_STAGES-1];
        assign datS = datSync_q[SYNC_STAGES-1];
    end

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .din_i   (datS),
        .dout_o  (fifoDout),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (level)
    );

    assign baudDone = (baudCnt_q == '0);
    assign uart_tx  = tx_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) || (level != '0);

    // Toggle detection and sticky overflow; a drop in the same cycle as clr_ovf keeps the flag set.
    always_comb begin
        fifoPush = (ctlS != ctlRef_q);
        ovf_d    = ovf_q;
        if (fifoPush && fifoFull && !fifoPop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State register plus all datapath registers of the input stage and transmitter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            tx_q      <= UART_IDLE_LEVEL;
            ctlRef_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            if (fifoPush) begin
                ctlRef_q <= ctlS;
            end
        end
    end

    // Next-state logic; the stop bit chains straight into the next start bit when data is waiting.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        fifoPop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    shift_d   = fifoDout;
                    baudCnt_d = BAUD_RELOAD;
                    state_d   = START;
                end
            end
            START: begin
                if (baudDone) begin
                    baudCnt_d = BAUD_RELOAD;
                    bitCnt_d  = '0;
                    state_d   = DATA;
                end else begin
                    baudCnt_d = baudCnt_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baudDone) begin
                    baudCnt_d = BAUD_RELOAD;
                    shift_d   = shift_q >> 1;
                    if (bitCnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q - BAUD_W'(1);
                end
            end
            STOP: begin
                if (baudDone) begin
                    if (!fifoEmpty) begin
                        fifoPop   = 1'b1;
                        shift_d   = fifoDout;
                        baudCnt_d = BAUD_RELOAD;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baudCnt_d = baudCnt_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level derived from the upcoming state so the registered output changes with the state.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Self-checking bench for out_port_uart_tx: a timing-level model predicts which bytes
// are accepted and when each frame starts, and a line decoder recovers the frames.
module tb_out_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DEP   = 4;
    localparam int LVLW  = $clog2(DEP) + 1;
    localparam int FRAME = 10 * CPB;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      in_dat;
    logic            in_ctl;
    logic            clr_ovf;
    logic            uart_tx;
    logic            busy;
    logic            overflow;
    logic [LVLW-1:0] level;
    logic            syncTx;
    logic            syncBusy;
    logic            syncOvf;
    logic [LVLW-1:0] syncLevel;

    int checkCnt = 0;
    int passCnt  = 0;
    int failCnt  = 0;
    int cyc      = 0;

    int         mPush[$];
    int         mPop[$];
    logic [7:0] expByte[$];
    int         expStart[$];
    int         lastPop = -100000;
    logic       ovfExp  = 1'b0;
    int         peakExp = 0;
    int         lastT   = 0;

    logic [7:0] rxByte[$];
    int         rxStart[$];
    bit         rxOk[$];
    bit         monBusy = 1'b0;
    int         monStart;
    int         monOff;
    int         monBit;
    logic [7:0] monByte;
    bit         monOk;
    int         maxLevel = 0;

    out_port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEP),
        .SYNC_STAGES  (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_dat   (in_dat),
        .in_ctl   (in_ctl),
        .clr_ovf  (clr_ovf),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .overflow (overflow),
        .level    (level)
    );

    out_port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEP),
        .SYNC_STAGES  (2)
    ) dutSync (
        .clk      (clk),
        .rst      (rst),
        .in_dat   (in_dat),
        .in_ctl   (in_ctl),
        .clr_ovf  (clr_ovf),
        .uart_tx  (syncTx),
        .busy     (syncBusy),
        .overflow (syncOvf),
        .level    (syncLevel)
    );

    // Free-running clock and cycle counter shared by stimulus, model and decoder.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Line decoder: finds a falling edge, then samples each bit in the middle of its slot.
    always @(negedge clk) begin
        if (rst) begin
            monBusy = 1'b0;
        end else begin
            if (int'(level) > maxLevel) begin
                maxLevel = int'(level);
            end
            if (!monBusy) begin
                if (uart_tx === 1'b0) begin
                    monBusy  = 1'b1;
                    monStart = cyc;
                    monOk    = 1'b1;
                    monByte  = 8'h00;
                end
            end else begin
                monOff = cyc - monStart;
                if ((monOff % CPB) == (CPB / 2)) begin
                    monBit = monOff / CPB;
                    if (monBit == 0) begin
                        if (uart_tx !== 1'b0) monOk = 1'b0;
                    end else if (monBit <= 8) begin
                        monByte[monBit-1] = uart_tx;
                    end else begin
                        if (uart_tx !== 1'b1) monOk = 1'b0;
                        rxByte.push_back(monByte);
                        rxStart.push_back(monStart);
                        rxOk.push_back(monOk);
                        monBusy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            clr_ovf = 1'b0;
        end
    endtask

    // Toggle the strobe with a new byte and predict acceptance and frame start time.
    task automatic applyStimulus(input logic [7:0] d, input logic clr, input int spacing);
        int p;
        int occ;
        int pop;
        in_dat  = d;
        in_ctl  = ~in_ctl;
        clr_ovf = clr;
        lastT   = cyc;
        p       = cyc + 1;
        occ     = 0;
        foreach (mPush[i]) begin
            if (mPush[i] < p && mPop[i] > p) occ++;
        end
        if (occ < DEP) begin
            pop = (p + 1 > lastPop + FRAME) ? p + 1 : lastPop + FRAME;
            mPush.push_back(p);
            mPop.push_back(pop);
            expByte.push_back(d);
            expStart.push_back(pop);
            lastPop = pop;
            if (occ + 1 > peakExp) peakExp = occ + 1;
            if (clr) ovfExp = 1'b0;
        end else begin
            ovfExp = 1'b1;
        end
        stepCycles(spacing);
    endtask

    task automatic clrPulse();
        clr_ovf = 1'b1;
        ovfExp  = 1'b0;
        stepCycles(1);
    endtask

    task automatic resetModel();
        mPush.delete();
        mPop.delete();
        expByte.delete();
        expStart.delete();
        rxByte.delete();
        rxStart.delete();
        rxOk.delete();
        lastPop = -100000;
        ovfExp  = 1'b0;
        peakExp = 0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((busy || monBusy) && n < 3000) begin
            stepCycles(1);
            n++;
        end
        checkOutput($sformatf("%s_idle", tag), 32'(busy || monBusy), 32'd0);
    endtask

    task automatic compareFrames(input string tag);
        int n;
        checkOutput($sformatf("%s_frameCount", tag), 32'(rxByte.size()), 32'(expByte.size()));
        n = (rxByte.size() < expByte.size()) ? rxByte.size() : expByte.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rxByte[i]), 32'(expByte[i]));
            checkOutput($sformatf("%s_start%0d", tag, i), 32'(rxStart[i]), 32'(expStart[i]));
            checkOutput($sformatf("%s_framing%0d", tag, i), 32'(rxOk[i]), 32'd1);
        end
        rxByte.delete();
        rxStart.delete();
        rxOk.delete();
        expByte.delete();
        expStart.delete();
    endtask

    initial begin
        int t;
        logic [7:0] b;

        rst     = 1'b1;
        in_ctl  = 1'b0;
        in_dat  = 8'h00;
        clr_ovf = 1'b0;
        stepCycles(3);
        checkOutput("rst_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_syncTx", 32'(syncTx), 32'd1);
        rst = 1'b0;
        stepCycles(2);

        $display("[TB] single byte 0x41");
        maxLevel = 0;
        peakExp  = 0;
        applyStimulus(8'h41, 1'b0, 1);
        checkOutput("s1_levelAtPush", 32'(level), 32'd1);
        checkOutput("s1_txBeforeStart", 32'(uart_tx), 32'd1);
        checkOutput("s1_busyAtPush", 32'(busy), 32'd1);
        stepCycles(1);
        checkOutput("s1_txStartEdge", 32'(uart_tx), 32'd0);
        checkOutput("s1_levelAfterPop", 32'(level), 32'd0);
        waitIdle("s1");
        compareFrames("s1");
        checkOutput("s1_peakLevel", 32'(maxLevel), 32'd1);

        $display("[TB] both toggle directions");
        applyStimulus(8'h48, 1'b0, 3);
        applyStimulus(8'h69, 1'b0, 3);
        waitIdle("s2");
        compareFrames("s2");

        $display("[TB] burst of five bytes");
        maxLevel = 0;
        peakExp  = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'($urandom), 1'b0, 3);
        end
        waitIdle("s3");
        for (int i = 0; i + 1 < rxStart.size(); i++) begin
            checkOutput($sformatf("s3_backToBack%0d", i), 32'(rxStart[i+1] - rxStart[i]), 32'(FRAME));
        end
        compareFrames("s3");
        checkOutput("s3_peakLevel", 32'(maxLevel), 32'(peakExp));
        checkOutput("s3_overflow", 32'(overflow), 32'd0);

        $display("[TB] overflow with seven toggles");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(8'($urandom), 1'b0, 3);
        end
        checkOutput("s4_overflowSet", 32'(overflow), 32'(ovfExp));
        checkOutput("s4_levelFull", 32'(level), 32'(DEP));
        clrPulse();
        checkOutput("s4_overflowCleared", 32'(overflow), 32'd0);
        applyStimulus(8'($urandom), 1'b1, 3);
        checkOutput("s4_setWinsOverClear", 32'(overflow), 32'(ovfExp));
        checkOutput("s4_levelStillFull", 32'(level), 32'(DEP));
        waitIdle("s4");
        compareFrames("s4");
        clrPulse();
        checkOutput("s4_overflowFinal", 32'(overflow), 32'd0);

        $display("[TB] reset during a data bit");
        applyStimulus(8'($urandom), 1'b0, 3);
        applyStimulus(8'($urandom), 1'b0, 3);
        t = expStart[0];
        stepCycles(t + 4 * CPB + 1 - cyc);
        rst    = 1'b1;
        in_ctl = 1'b0;
        #1;
        checkOutput("s5_rstTx", 32'(uart_tx), 32'd1);
        checkOutput("s5_rstLevel", 32'(level), 32'd0);
        checkOutput("s5_rstBusy", 32'(busy), 32'd0);
        resetModel();
        stepCycles(2);
        rst = 1'b0;
        stepCycles(2);
        checkOutput("s5_noSpuriousPush", 32'(level), 32'd0);
        applyStimulus(8'h5A, 1'b0, 3);
        waitIdle("s5");
        compareFrames("s5");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(8'($urandom), 1'b0, int'($urandom_range(45, 2)));
        end
        checkOutput("s6_overflow", 32'(overflow), 32'(ovfExp));
        waitIdle("s6");
        compareFrames("s6");
        clrPulse();

        $display("[TB] two synchronizer stages, byte 0x55");
        stepCycles(6);
        checkOutput("s7_syncIdle", 32'(syncBusy), 32'd0);
        b = 8'h55;
        applyStimulus(b, 1'b0, 1);
        t = lastT;
        stepCycles(t + 3 - cyc);
        checkOutput("s7_txBeforeStart", 32'(syncTx), 32'd1);
        stepCycles(1);
        checkOutput("s7_txStartEdge", 32'(syncTx), 32'd0);
        for (int j = 1; j <= 9; j++) begin
            stepCycles(t + 4 + j * CPB + 1 - cyc);
            checkOutput($sformatf("s7_bit%0d", j), 32'(syncTx), (j <= 8) ? 32'((b >> (j - 1)) & 8'h01) : 32'd1);
        end
        waitIdle("s7");
        compareFrames("s7");
        stepCycles(4);
        checkOutput("s7_syncDone", 32'(syncBusy), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
